// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//   Instruction fetch plus the IF/ID pipeline register of the single-issue
//   datapath. It owns the program counter and runs a request/ready handshake
//   with instruction memory. Each accepted word is latched with its PC and
//   split into opcode, register and 21-bit immediate fields. id_imm21 feeds
//   the A input of the downstream sign_extend block.
//
// Parameters
//   RESET_PC  PC loaded on reset (bits [1:0] must be zero)
//   PC_STEP   sequential PC increment in bytes
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_req/imem_addr         fetch request and address (address = pc register)
//   imem_rdata/imem_ready      instruction word, accepted together with the request
//   stall, flush               decode back-pressure, ID invalidate
//   branch_taken/branch_target PC redirect
//   id_valid, id_pc, id_instr  IF/ID register contents
//   id_opcode, id_rd, id_rs,
//   id_rt, id_imm21            instruction fields, pure wiring from id_instr
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [20:0] id_imm21
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;

  logic        accept;
  logic [31:0] target_aligned;

  // Masking (rather than slicing) keeps every target bit in use.
  assign target_aligned = branch_target & ~32'h3;

  // A held, live ID instruction blocks new requests; an empty ID register
  // may still be refilled while decode reports stall.
  assign imem_req = (state_q == S_FETCH) && !(stall && id_valid_q);
  assign accept   = imem_req && imem_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (flush) id_valid_d = 1'b0;
      end

      S_FETCH, S_REDIRECT: begin
        if (branch_taken) begin
          // Redirect wins over stall, flush and any word fetched this cycle.
          pc_d       = target_aligned;
          id_valid_d = 1'b0;
          state_d    = S_REDIRECT;
        end else if (state_q == S_REDIRECT) begin
          state_d = S_FETCH;
          if (flush) id_valid_d = 1'b0;
        end else if (flush) begin
          // Drop any word accepted now; pc stays so it is fetched again.
          id_valid_d = 1'b0;
        end else if (accept) begin
          id_instr_d = imem_rdata;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + PC_STEP;
        end else if (!stall) begin
          id_valid_d = 1'b0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        id_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_opcode = id_instr_q[31:26];
  assign id_rd     = id_instr_q[25:21];
  assign id_rs     = id_instr_q[20:16];
  assign id_rt     = id_instr_q[15:11];
  assign id_imm21  = id_instr_q[20:0];

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Instruction fetch and IF/ID pipeline stage of the single-issue datapath. Keeps the program counter and runs a request/ready handshake with instruction memory. Registers each accepted instruction together with its PC, and splits it into opcode, register and 21-bit immediate fields. The `id_imm21` output drives the `A` input of the downstream `sign_extend` block directly, which widens it to 32 bits for the execute stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `PC_STEP`, default 4: sequential PC increment in bytes.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (registered PC).
- `imem_rdata`  in  32  instruction word; valid whenever `imem_ready`=1.
- `imem_ready`  in  1  memory accepts the request and returns data in the same cycle.
- `stall`  in  1  decode cannot accept a new instruction this cycle.
- `flush`  in  1  invalidate the ID register.
- `branch_taken`  in  1  redirect the PC to `branch_target`.
- `branch_target`  in  32  redirect address; bits [1:0] are forced to 0 internally.
- `id_valid`  out  1  ID register holds a live instruction.
- `id_pc`  out  32  PC of the ID instruction.
- `id_instr`  out  32  raw instruction.
- `id_opcode`  out  6  `id_instr`[31:26].
- `id_rd`  out  5  `id_instr`[25:21].
- `id_rs`  out  5  `id_instr`[20:16].
- `id_rt`  out  5  `id_instr`[15:11].
- `id_imm21`  out  21  `id_instr`[20:0]; feeds `sign_extend.A`.

## Operation
- **States:** IDLE, FETCH, REDIRECT. All state is updated on the rising edge of `clk`.
- **Reset** (`rst_n`=0 at an edge) produces:
  - state=IDLE, pc=`RESET_PC`, `imem_req`=0, `id_valid`=0, `id_pc`=0, `id_instr`=0, so all field outputs are 0.
  - Reset overrides every other input, including an access in progress mid-handshake; that access is dropped.
- **IDLE:** `imem_req`=0. Moves to FETCH unconditionally on the next edge.
- **FETCH:**
  - `imem_req` = !(`stall` && `id_valid`).
  - An access is accepted when `imem_req` && `imem_ready`.
  - On accept: `id_instr`<=`imem_rdata`, `id_pc`<=pc, `id_valid`<=1, pc<=pc+`PC_STEP`.
  - No accept and `stall`=0: `id_valid`<=0 (a bubble enters ID).
  - `stall`=1 and `id_valid`=1: the ID register and pc hold their values.
- **Branch redirect** (`branch_taken`=1 in any state other than IDLE):
  - Actions: pc<={`branch_target`[31:2],2'b00}, `id_valid`<=0, state<=REDIRECT.
  - It takes priority over `stall`, `flush` and any access accepted in the same cycle; that fetched word is discarded and pc is not incremented.
- **REDIRECT:** `imem_req`=0 for exactly one cycle (the branch penalty), then the state returns to FETCH. Another `branch_taken` seen in REDIRECT reloads pc and stays in REDIRECT.
- **Flush** (`flush`=1, `branch_taken`=0):
  - `id_valid`<=0; pc is unchanged.
  - An access accepted in the same cycle is discarded and pc is not incremented. That instruction is re-fetched later.
- **Width rules:**
  - The PC adder is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error flag.
  - The field outputs are pure wiring from `id_instr`.
- `id_instr` and its field outputs keep their last value when `id_valid`=0; consumers must qualify them with `id_valid`.

## Timing
- `imem_addr` is driven only from the pc register, with no combinational path from any input.
- `imem_req` depends combinationally on `stall`, `id_valid` and state.
- An instruction accepted at edge N appears on `id_*` after edge N, with `id_valid`=1. Latency from accept to ID is 1 cycle.
- With `imem_ready` held at 1 and no stall, throughput is one instruction per cycle.
- The first request is raised in the cycle after reset is released plus one IDLE cycle. With `RESET_PC`=0, the first accepted address is 0.
- The branch penalty is 2 cycles from the `branch_taken` edge to the next `id_valid`=1: one REDIRECT cycle plus one fetch cycle.
- `sign_extend` is combinational; its 32-bit output is valid in the same cycle as `id_valid`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → `imem_req`=0 for 1 cycle, then `imem_req`=1 with `imem_addr`=0; all `id_*` outputs read 0 throughout reset.
- **Stream:** `imem_ready`=1, memory returns words 32'h0C20_0001, 32'h0C3F_FFFF, ... → `id_pc` steps 0, 4, 8; `id_imm21` reads 21'h000001 then 21'h1FFFFF; `sign_extend.out` reads 32'h0000_0001 then 32'hFFFF_FFFF.
- **Stall:** assert `stall` for 3 cycles while `id_valid`=1 at `id_pc`=8 → `imem_req`=0, `id_pc`=8 and `id_instr` are held, pc=12 is held; after release, the next accepted address is 12.
- **Branch and flush:**
  - Pulse `branch_taken` with `branch_target`=32'h0000_0103 during an accepted fetch → the fetched word is dropped, `id_valid`=0, REDIRECT lasts 1 cycle, the next fetch goes to `imem_addr`=32'h100, and `id_valid`=1 two cycles after the pulse.
  - Repeat with `flush` only → `id_valid`=0 for one cycle and the same address is re-fetched.
- **Wrap:** set pc to 32'hFFFF_FFFC via a branch and accept one fetch → `id_pc`=32'hFFFF_FFFC, then the next `imem_addr`=0.
- **Reset mid-operation:** drop `rst_n` in a cycle where `imem_ready`=1 and `stall`=1 → on the next edge `id_valid`=0 and state=IDLE; after release, fetching restarts from `RESET_PC` with no stale `id_valid`.
